// File: rtl/seq_generator_param_if.sv
// Output stream of the recurrence generator: one term per transfer, tagged
// with its index. A transfer happens on a rising edge where out_valid and
// out_ready are both high.
//   out_valid : producer holds a term
//   out_ready : consumer accepts the term
//   out_data  : term value
//   out_index : index of the term, starting at 0
interface seq_generator_param_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [IDX_W-1:0] out_index;

  modport master (output out_valid, output out_data, output out_index, input out_ready);
  modport slave  (input out_valid, input out_data, input out_index, output out_ready);
endinterface

// File: rtl/seq_generator_param.sv
// Two-term recurrence generator: term(n) = term(n-1) + term(n-2) with
// programmable seeds (0,1 -> Fibonacci; 2,1 -> Lucas), emitted on a
// back-pressurable valid/ready stream.
//   clk, rst            : clock, asynchronous active-high reset
//   start, abort        : begin a run (IDLE/DONE only) / end it, back to IDLE
//   seed0, seed1        : first two terms, sampled on an accepted start
//   num_terms           : terms to emit, 0 = unlimited, sampled on start
//   wrap_mode           : 0 = stop at last representable term, 1 = wrap
//   st (master)         : out_valid/out_ready/out_data/out_index stream
//   overflow            : sticky, a computed term exceeded 2^WIDTH-1 this run
//   done, busy          : DONE state / RUN state
module seq_generator_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WIDTH-1:0]      seed0,
  input  logic [WIDTH-1:0]      seed1,
  input  logic [IDX_W-1:0]      num_terms,
  input  logic                  wrap_mode,
  seq_generator_param_if.master st,
  output logic                  overflow,
  output logic                  done,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a;          // current term
  logic [WIDTH-1:0] b;          // next term
  logic [IDX_W-1:0] idx;        // index of a
  logic             b_bad;      // b is a truncated (overflowed) value
  logic [IDX_W-1:0] nterms_q;
  logic             wrap_q;

  logic [WIDTH:0]   sum_c;
  logic             xfer_c;
  logic             last_c;

  assign sum_c  = {1'b0, a} + {1'b0, b};
  assign xfer_c = st.out_valid && st.out_ready;
  assign last_c = (nterms_q != '0) && (idx == nterms_q - IDX_W'(1));

  // Run control, term recurrence and registered stream/status outputs.
  // out_data/out_index are kept apart from a/idx so they can hold the last
  // emitted term in DONE while a/idx have already advanced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      a            <= '0;
      b            <= '0;
      idx          <= '0;
      b_bad        <= 1'b0;
      nterms_q     <= '0;
      wrap_q       <= 1'b0;
      st.out_valid <= 1'b0;
      st.out_data  <= '0;
      st.out_index <= '0;
      overflow     <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (abort) begin
            state <= IDLE;
            done  <= 1'b0;
          end else if (start) begin
            state        <= RUN;
            a            <= seed0;
            b            <= seed1;
            idx          <= '0;
            b_bad        <= 1'b0;
            nterms_q     <= num_terms;
            wrap_q       <= wrap_mode;
            overflow     <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b1;
            st.out_valid <= 1'b1;
            st.out_data  <= seed0;
            st.out_index <= '0;
          end
        end

        RUN: begin
          // A transfer always advances the recurrence, even when aborted.
          if (xfer_c) begin
            a   <= b;
            b   <= sum_c[WIDTH-1:0];
            idx <= idx + IDX_W'(1);
            if (sum_c[WIDTH]) begin
              overflow <= 1'b1;
              b_bad    <= 1'b1;
            end
          end

          if (abort) begin
            state        <= IDLE;
            st.out_valid <= 1'b0;
            busy         <= 1'b0;
          end else if (xfer_c) begin
            // Stop on the term limit, or before emitting a truncated term.
            if (last_c || (!wrap_q && b_bad)) begin
              state        <= DONE;
              st.out_valid <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
            end else begin
              st.out_data  <= b;
              st.out_index <= idx + IDX_W'(1);
            end
          end
        end

        default: begin
          state        <= IDLE;
          st.out_valid <= 1'b0;
          busy         <= 1'b0;
          done         <= 1'b0;
        end
      endcase
    end
  end

endmodule
